// File: rtl/keypad_scanner_pkg.sv
// Shared keypad definitions: debounce states and one-hot {row,col} key codes
// used by the scanner, its bench and the downstream keypad FSM.
package keypad_pkg;

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} db_state_e;

  localparam logic [7:0] NO_KEY = 8'd0;

  // Layout: R0 = 1 2 3 A, R1 = 4 5 6 B, R2 = 7 8 9 C, R3 = * 0 # D
  localparam logic [7:0] KEY_1        = 8'b1000_1000;
  localparam logic [7:0] KEY_7        = 8'b0010_1000;
  localparam logic [7:0] KEY_9        = 8'b0010_0010;
  localparam logic [7:0] KEY_A        = 8'b1000_0001;
  localparam logic [7:0] KEY_B        = 8'b0100_0001;
  localparam logic [7:0] KEY_D        = 8'b0001_0001;
  localparam logic [7:0] KEY_SUBMIT   = 8'b0001_0010;
  localparam logic [7:0] KEY_CLEAR    = 8'b0001_1000;
  localparam logic [7:0] KEY_GAME_END = 8'b0010_0001;

  function automatic logic [7:0] key_code(input int unsigned row, input int unsigned col);
    logic [3:0] top;
    top = 4'b1000;
    return {top >> row, top >> col};
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad pin and key-event bundle; master is the scanner, slave the pads/consumer.
interface keypad_scanner_if;
  logic [3:0] col_in;
  logic [3:0] row_out;
  logic [7:0] cur_key;
  logic       strobe;

  modport master (input col_in, output row_out, output cur_key, output strobe);
  modport slave  (output col_in, input row_out, input cur_key, input strobe);
endinterface

// File: rtl/keypad_scanner_sync.sv
// WIDTH-bit two-flop synchronizer for asynchronous pad inputs.
module keypad_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [WIDTH-1:0] meta_q, sync_q;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
    end
  end

  assign dout = sync_q;
endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad row scanner with whole-scan debounce and ghost rejection;
// emits the accepted one-hot key code and a single-cycle press strobe.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 100,
  parameter int DEBOUNCE_SCANS = 4
) (
  input logic              clk,
  input logic              nRst,
  keypad_scanner_if.master kp
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_SCANS - 1);

  logic [3:0]      col_s;
  logic [DW-1:0]   div_q, div_d;
  logic [3:0]      row_q, row_d;
  logic [3:0][3:0] cap_q, cap_d, full;
  db_state_e       state_q, state_d;
  logic [7:0]      key_q, key_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      cur_key_q, cur_key_d;
  logic            strobe_q, strobe_d;
  logic            sample, scan_end, accept, rel;
  logic [4:0]      pop;
  logic [3:0]      rows_any, cols_any;
  logic [7:0]      cand;

  keypad_sync #(.WIDTH(4)) u_sync (
    .clk  (clk),
    .nRst (nRst),
    .din  (kp.col_in),
    .dout (col_s)
  );

  assign sample   = (div_q == DIV_LAST);
  assign scan_end = sample && row_q[0];

  always_comb begin
    div_d = sample ? '0 : div_q + 1'b1;
    row_d = sample ? {row_q[0], row_q[3:1]} : row_q;
  end

  // cap_q[i] holds the columns seen while row_q[i] was driven; the live row
  // is patched in so the full 16-bit picture is ready on the R3 sample cycle.
  always_comb begin
    cap_d    = cap_q;
    full     = cap_q;
    rows_any = '0;
    cols_any = '0;
    for (int i = 0; i < 4; i++) begin
      if (row_q[i]) full[i] = col_s;
      if (sample && row_q[i]) cap_d[i] = col_s;
      rows_any[i] = |full[i];
      cols_any    = cols_any | full[i];
    end
    pop  = 5'($countones(full));
    cand = (pop == 5'd1) ? {rows_any, cols_any} : NO_KEY;
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    rel     = 1'b0;
    if (scan_end) begin
      case (state_q)
        IDLE: begin
          if (cand != NO_KEY) begin
            key_d = cand;
            if (DEBOUNCE_SCANS == 1) begin
              state_d = HELD;
              cnt_d   = '0;
              accept  = 1'b1;
            end else begin
              state_d = PRESS_DB;
              cnt_d   = CW'(1);
            end
          end
        end
        PRESS_DB: begin
          if (cand == key_q) begin
            if (cnt_q == CNT_LAST) begin
              state_d = HELD;
              cnt_d   = '0;
              accept  = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else if (cand != NO_KEY) begin
            key_d = cand;
            cnt_d = CW'(1);
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        HELD: begin
          // Any change, including a second key (ghost -> cand 0), starts release.
          if (cand != key_q) begin
            if (DEBOUNCE_SCANS == 1) begin
              state_d = IDLE;
              rel     = 1'b1;
            end else begin
              state_d = REL_DB;
              cnt_d   = CW'(1);
            end
          end
        end
        REL_DB: begin
          if (cand == key_q) begin
            state_d = HELD;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
            rel     = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    strobe_d  = accept;
    cur_key_d = accept ? key_d : (rel ? NO_KEY : cur_key_q);
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      div_q     <= '0;
      row_q     <= 4'b1000;
      cap_q     <= '0;
      state_q   <= IDLE;
      key_q     <= NO_KEY;
      cnt_q     <= '0;
      cur_key_q <= NO_KEY;
      strobe_q  <= 1'b0;
    end else begin
      div_q     <= div_d;
      row_q     <= row_d;
      cap_q     <= cap_d;
      state_q   <= state_d;
      key_q     <= key_d;
      cnt_q     <= cnt_d;
      cur_key_q <= cur_key_d;
      strobe_q  <= strobe_d;
    end
  end

  assign kp.row_out = row_q;
  assign kp.cur_key = cur_key_q;
  assign kp.strobe  = strobe_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad pad model plus a scan-level press/release
// reference built from run lengths of the single-key candidate per scan.
module tb_keypad_scanner;
  import keypad_pkg::*;

  localparam int SD   = 4;
  localparam int DS   = 3;
  localparam int SCAN = 4 * SD;

  logic clk = 1'b0;
  logic nRst = 1'b0;
  always #5 clk = ~clk;

  keypad_scanner_if kp ();

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
    .clk  (clk),
    .nRst (nRst),
    .kp   (kp)
  );

  // keys[r*4+c] = key at row r, column c is pressed
  logic [15:0] keys = '0;
  int cyc;
  int npass = 0;
  int ntot  = 0;

  always @(posedge clk) begin
    logic [3:0] c;
    c = '0;
    for (int r = 0; r < 4; r++)
      if (kp.row_out[3-r])
        for (int k = 0; k < 4; k++)
          if (keys[r*4+k]) c[3-k] = 1'b1;
    kp.col_in <= c;
  end

  always @(posedge clk or negedge nRst)
    if (!nRst) cyc <= 0;
    else       cyc <= cyc + 1;

  // ---------------- reference model ----------------
  logic       exp_strobe, pend_stb, m_hold;
  logic [7:0] exp_key, pend_key, m_held, m_skey;
  int         m_streak, m_rel;

  function automatic logic [7:0] cand_of(input logic [15:0] k);
    logic [3:0] one;
    one = 4'b1000;
    if ($countones(k) != 1) return 8'd0;
    for (int i = 0; i < 16; i++)
      if (k[i]) return {one >> (i / 4), one >> (i % 4)};
    return 8'd0;
  endfunction

  always begin
    @(posedge clk);
    #1;
    if (!nRst) begin
      exp_strobe = 1'b0; exp_key = 8'd0; pend_stb = 1'b0; pend_key = 8'd0;
      m_hold = 1'b0; m_held = 8'd0; m_skey = 8'd0; m_streak = 0; m_rel = 0;
    end else begin
      logic [7:0] c;
      exp_strobe = 1'b0;
      if (cyc % SCAN == 0 && cyc != 0) begin
        exp_strobe = pend_stb;
        exp_key    = pend_key;
      end
      if (cyc % SCAN == 1) begin
        c = cand_of(keys);
        pend_stb = 1'b0;
        if (!m_hold) begin
          if (c == 8'd0) m_streak = 0;
          else if (c == m_skey && m_streak > 0) m_streak++;
          else begin m_skey = c; m_streak = 1; end
          if (m_streak == DS) begin
            m_hold = 1'b1; m_held = c; m_streak = 0; m_rel = 0; pend_stb = 1'b1;
          end
        end else begin
          if (c == m_held) m_rel = 0;
          else m_rel++;
          if (m_rel == DS) begin m_hold = 1'b0; m_rel = 0; m_streak = 0; end
        end
        pend_key = m_hold ? m_held : 8'd0;
      end
    end
  end

  // Park at the negedge two cycles before a scan starts so new keys cover a whole scan.
  task automatic align();
    int n = 0;
    while (cyc % SCAN != SCAN - 2 && n < 64) begin
      @(negedge clk);
      n++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [3:0] er;
    repeat (3) @(negedge clk);
    ntot++; if (kp.row_out !== 4'b1000) $display("FAIL reset_row got=%b exp=1000", kp.row_out); else npass++;
    ntot++; if (kp.cur_key !== 8'd0) $display("FAIL reset_key got=%b exp=0", kp.cur_key); else npass++;
    ntot++; if (kp.strobe !== 1'b0) $display("FAIL reset_strobe got=%b exp=0", kp.strobe); else npass++;
    nRst = 1'b1;
    repeat (3 * SCAN) begin
      @(negedge clk);
      er = 4'b1000 >> ((cyc / SD) % 4);
      ntot++;
      if (kp.row_out !== er || kp.strobe !== 1'b0 || kp.cur_key !== 8'd0)
        $display("FAIL idle_scan cyc=%0d row=%b/%b strobe=%b key=%b", cyc, kp.row_out, er, kp.strobe, kp.cur_key);
      else npass++;
    end
  endtask

  task automatic test_hold_release();
    logic [15:0] pk [2] = '{16'h0100, 16'h0000};
    int          pn [2] = '{10, 5};
    int nstb [2] = '{0, 0};
    int soff = -1;
    logic [7:0] skey = 8'd0, end0 = 8'd0;
    for (int p = 0; p < 2; p++) begin
      align();
      keys = pk[p];
      for (int i = 1; i <= pn[p] * SCAN; i++) begin
        @(negedge clk);
        ntot++;
        if (kp.strobe !== exp_strobe || kp.cur_key !== exp_key)
          $display("FAIL hold cyc=%0d strobe=%b/%b key=%b/%b", cyc, kp.strobe, exp_strobe, kp.cur_key, exp_key);
        else npass++;
        if (kp.strobe) begin nstb[p]++; skey = kp.cur_key; if (p == 0) soff = i; end
      end
      if (p == 0) end0 = kp.cur_key;
    end
    ntot++; if (nstb[0] !== 1) $display("FAIL hold_strobes got=%0d exp=1", nstb[0]); else npass++;
    ntot++; if (skey !== 8'b0010_1000) $display("FAIL hold_key got=%b exp=00101000", skey); else npass++;
    ntot++; if (soff !== DS * SCAN + 2) $display("FAIL hold_latency got=%0d exp=%0d", soff, DS * SCAN + 2); else npass++;
    ntot++; if (end0 !== 8'b0010_1000) $display("FAIL hold_kept got=%b exp=00101000", end0); else npass++;
    ntot++; if (nstb[1] !== 0 || kp.cur_key !== 8'd0)
      $display("FAIL release got strobes=%0d key=%b exp 0/0", nstb[1], kp.cur_key); else npass++;
  endtask

  task automatic test_bounce();
    logic [15:0] pk [10] = '{16'h0020, 16'h0, 16'h0020, 16'h0, 16'h0020, 16'h0,
                             16'h0020, 16'h0, 16'h0020, 16'h0};
    int          pn [10] = '{1, 1, 1, 1, 1, 1, 1, 1, 6, 5};
    int bounce_stb = 0, stable_stb = 0, soff = -1;
    logic [7:0] skey = 8'd0;
    for (int p = 0; p < 10; p++) begin
      align();
      keys = pk[p];
      for (int i = 1; i <= pn[p] * SCAN; i++) begin
        @(negedge clk);
        ntot++;
        if (kp.strobe !== exp_strobe || kp.cur_key !== exp_key)
          $display("FAIL bounce cyc=%0d strobe=%b/%b key=%b/%b", cyc, kp.strobe, exp_strobe, kp.cur_key, exp_key);
        else npass++;
        if (kp.strobe) begin
          if (p < 8) bounce_stb++;
          else if (p == 8) begin stable_stb++; skey = kp.cur_key; soff = i; end
        end
      end
    end
    ntot++; if (bounce_stb !== 0) $display("FAIL bounce_strobes got=%0d exp=0", bounce_stb); else npass++;
    ntot++; if (stable_stb !== 1 || skey !== 8'b0100_0100)
      $display("FAIL bounce_accept got n=%0d key=%b exp 1/01000100", stable_stb, skey); else npass++;
    ntot++; if (soff !== DS * SCAN + 2) $display("FAIL bounce_latency got=%0d exp=%0d", soff, DS * SCAN + 2); else npass++;
  endtask

  task automatic test_ghost();
    logic [15:0] pk [2] = '{16'h0022, 16'h0000};
    int          pn [2] = '{8, 2};
    int nstb = 0;
    logic seen_key = 1'b0;
    for (int p = 0; p < 2; p++) begin
      align();
      keys = pk[p];
      repeat (pn[p] * SCAN) begin
        @(negedge clk);
        ntot++;
        if (kp.strobe !== exp_strobe || kp.cur_key !== exp_key)
          $display("FAIL ghost cyc=%0d strobe=%b/%b key=%b/%b", cyc, kp.strobe, exp_strobe, kp.cur_key, exp_key);
        else npass++;
        if (kp.strobe) nstb++;
        if (kp.cur_key != 8'd0) seen_key = 1'b1;
      end
    end
    ntot++; if (nstb !== 0 || seen_key !== 1'b0)
      $display("FAIL ghost_reject got strobes=%0d key_seen=%b exp 0/0", nstb, seen_key); else npass++;
  endtask

  task automatic test_rollover();
    logic [15:0] pk [4] = '{16'h1000, 16'h5000, 16'h4000, 16'h0000};
    int          pn [4] = '{5, 4, 7, 5};
    int nstb [4] = '{0, 0, 0, 0};
    logic [7:0] skey [4] = '{8'd0, 8'd0, 8'd0, 8'd0};
    logic [7:0] end1 = 8'hff;
    for (int p = 0; p < 4; p++) begin
      align();
      keys = pk[p];
      repeat (pn[p] * SCAN) begin
        @(negedge clk);
        ntot++;
        if (kp.strobe !== exp_strobe || kp.cur_key !== exp_key)
          $display("FAIL rollover cyc=%0d strobe=%b/%b key=%b/%b", cyc, kp.strobe, exp_strobe, kp.cur_key, exp_key);
        else npass++;
        if (kp.strobe) begin nstb[p]++; skey[p] = kp.cur_key; end
      end
      if (p == 1) end1 = kp.cur_key;
    end
    ntot++; if (nstb[0] !== 1 || skey[0] !== 8'b0001_1000)
      $display("FAIL roll_first got n=%0d key=%b exp 1/00011000", nstb[0], skey[0]); else npass++;
    ntot++; if (nstb[1] !== 0 || end1 !== 8'd0)
      $display("FAIL roll_both got n=%0d key=%b exp 0/0", nstb[1], end1); else npass++;
    ntot++; if (nstb[2] !== 1 || skey[2] !== 8'b0001_0010)
      $display("FAIL roll_second got n=%0d key=%b exp 1/00010010", nstb[2], skey[2]); else npass++;
  endtask

  task automatic test_reset_mid();
    int nstb [2] = '{0, 0};
    logic [7:0] skey [2] = '{8'd0, 8'd0};
    for (int p = 0; p < 2; p++) begin
      if (p == 1) begin
        nRst = 1'b0;
        #1;
        ntot++; if (kp.cur_key !== 8'd0 || kp.row_out !== 4'b1000 || kp.strobe !== 1'b0)
          $display("FAIL midreset got key=%b row=%b strobe=%b exp 0/1000/0", kp.cur_key, kp.row_out, kp.strobe);
        else npass++;
        repeat (2) @(negedge clk);
        nRst = 1'b1;
      end
      align();
      keys = 16'h0004;
      repeat (6 * SCAN) begin
        @(negedge clk);
        ntot++;
        if (kp.strobe !== exp_strobe || kp.cur_key !== exp_key)
          $display("FAIL reheld cyc=%0d strobe=%b/%b key=%b/%b", cyc, kp.strobe, exp_strobe, kp.cur_key, exp_key);
        else npass++;
        if (kp.strobe) begin nstb[p]++; skey[p] = kp.cur_key; end
      end
    end
    ntot++; if (nstb[0] !== 1 || skey[0] !== 8'b1000_0010)
      $display("FAIL pre_reset got n=%0d key=%b exp 1/10000010", nstb[0], skey[0]); else npass++;
    ntot++; if (nstb[1] !== 1 || skey[1] !== 8'b1000_0010)
      $display("FAIL post_reset got n=%0d key=%b exp 1/10000010", nstb[1], skey[1]); else npass++;
    align();
    keys = 16'h0;
    repeat (5 * SCAN) @(negedge clk);
  endtask

  task automatic test_random();
    logic [15:0] pat = '0;
    int nbad = 0;
    for (int s = 0; s < 40; s++) begin
      if ($urandom_range(99) >= 60) begin
        case ($urandom_range(3))
          0:       pat = '0;
          1, 2:    pat = 16'(1) << $urandom_range(15);
          default: pat = (16'(1) << $urandom_range(15)) | (16'(1) << $urandom_range(15));
        endcase
      end
      align();
      keys = pat;
      repeat (SCAN) begin
        @(negedge clk);
        ntot++;
        if (kp.strobe !== exp_strobe || kp.cur_key !== exp_key) begin
          nbad++;
          if (nbad < 10)
            $display("FAIL random cyc=%0d keys=%h strobe=%b/%b key=%b/%b", cyc, keys, kp.strobe, exp_strobe, kp.cur_key, exp_key);
        end else npass++;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_hold_release();
    test_bounce();
    test_ghost();
    test_rollover();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
